// File: rtl/shape_cfg_sequencer_if.sv
// rtl/shape_cfg_sequencer_if.sv - requester, response and shape-processor port bundle for shape_cfg_sequencer
interface shape_cfg_sequencer_if #(
    parameter int NUM_REQ = 2
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [2*NUM_REQ-1:0] req_shape;
    logic [5*NUM_REQ-1:0] req_operation;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_ok;
    logic                 sp_write;
    logic [31:0]          sp_write_data;
    logic                 sp_read;
    logic [31:0]          sp_read_data;
    logic                 busy;

    modport master (
        output req_valid, req_shape, req_operation, rsp_ready, sp_read_data,
        input  req_ready, rsp_valid, rsp_id, rsp_ok, sp_write, sp_write_data, sp_read, busy
    );

    modport slave (
        input  req_valid, req_shape, req_operation, rsp_ready, sp_read_data,
        output req_ready, rsp_valid, rsp_id, rsp_ok, sp_write, sp_write_data, sp_read, busy
    );
endinterface

// File: rtl/shape_cfg_sequencer.sv
// rtl/shape_cfg_sequencer.sv - round-robin write/readback sequencer; SHAPE_CFG_SEQ_PRECHECK_EN adds a legality precheck
module shape_cfg_sequencer #(
    parameter int NUM_REQ      = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shape_cfg_sequencer_if.slave  bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr, cap_id, grant_id;
    logic [1:0]          cap_shape, grant_shape;
    logic [4:0]          cap_op, grant_op;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic                grant_any;
    logic                pair_illegal;
    logic [2:0]          lat_cnt;
    logic                rsp_ok_q;
    logic                unused_rd;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + (ID_W+1)'(off);
        if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
        return sum[ID_W-1:0];
    endfunction

`ifdef SHAPE_CFG_SEQ_PRECHECK_EN
    function automatic logic legal_pair(input logic [1:0] shape, input logic [4:0] op);
        logic ok;
        ok = (shape == 2'b01) || (shape == 2'b10);
        case (op[4:3])
            2'b00:   ok = ok && (op[2:0] <= 3'd1);
            2'b01:   ok = ok && (op[2:0] == 3'd0) && (shape == 2'b01);
            2'b10:   ok = ok && (op[2:0] <= 3'd1) && (shape == 2'b10);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign pair_illegal = !legal_pair(grant_shape, grant_op);
`else
    assign pair_illegal = 1'b0;
`endif

    // Only the shape and operation fields take part in the readback compare.
    assign unused_rd = ^{bus.sp_read_data[31:18], bus.sp_read_data[15:5]};

    // Search starts at rr_ptr: the first offset that lands on a valid requester wins.
    always_comb begin
        grant_any    = 1'b0;
        grant_id     = '0;
        grant_onehot = '0;
        grant_shape  = '0;
        grant_op     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && bus.req_valid[i] && (wrap_add(rr_ptr, off) == ID_W'(i))) begin
                    grant_any       = 1'b1;
                    grant_id        = ID_W'(i);
                    grant_onehot[i] = 1'b1;
                    grant_shape     = bus.req_shape[2*i +: 2];
                    grant_op        = bus.req_operation[5*i +: 5];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        bus.req_ready     = '0;
        bus.sp_write      = 1'b0;
        bus.sp_write_data = '0;
        bus.sp_read       = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.rsp_id        = cap_id;
        bus.rsp_ok        = rsp_ok_q;
        bus.busy          = (state != IDLE);
        case (state)
            IDLE: begin
                bus.req_ready = grant_onehot;
                if (grant_any) state_nxt = pair_illegal ? RESP : WRITE;
            end
            WRITE: begin
                bus.sp_write      = 1'b1;
                bus.sp_write_data = {14'd0, cap_shape, 11'd0, cap_op};
                state_nxt         = READ;
            end
            READ: begin
                bus.sp_read = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 3'd1) state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            cap_id    <= '0;
            cap_shape <= '0;
            cap_op    <= '0;
            lat_cnt   <= '0;
            rsp_ok_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cap_id    <= grant_id;
                        cap_shape <= grant_shape;
                        cap_op    <= grant_op;
                        rsp_ok_q  <= 1'b0;
                    end
                end
                READ: lat_cnt <= 3'(READ_LATENCY);
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1)
                        rsp_ok_q <= (bus.sp_read_data[17:16] == cap_shape) &&
                                    (bus.sp_read_data[4:0] == cap_op);
                end
                RESP: begin
                    if (bus.rsp_ready) rr_ptr <= wrap_add(cap_id, 1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shape_cfg_sequencer.sv
// tb/tb_shape_cfg_sequencer.sv - bench for shape_cfg_sequencer at READ_LATENCY 1 and 3
module tb_shape_cfg_sequencer;
`ifdef SHAPE_CFG_SEQ_PRECHECK_EN
    localparam bit PRECHECK = 1'b1;
`else
    localparam bit PRECHECK = 1'b0;
`endif

    typedef struct {
        int         id;
        logic [1:0] shape;
        logic [4:0] op;
        bit         legal;
        bit         exp_ok;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [1:0]  req_valid;
    logic [3:0]  req_shape;
    logic [9:0]  req_op;
    logic        rsp_ready;
    logic [31:0] proc_reg = 32'h0;
    logic [2:0]  rd_sr = 3'b000;
    wire         rd_valid;
    wire  [31:0] rd_data;
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs[9];

    shape_cfg_sequencer_if #(.NUM_REQ(2)) bus_a ();
    shape_cfg_sequencer_if #(.NUM_REQ(2)) bus_b ();

    shape_cfg_sequencer #(.NUM_REQ(2), .READ_LATENCY(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    shape_cfg_sequencer #(.NUM_REQ(2), .READ_LATENCY(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign bus_a.req_valid     = sel ? 2'b00 : req_valid;
    assign bus_b.req_valid     = sel ? req_valid : 2'b00;
    assign bus_a.req_shape     = req_shape;
    assign bus_b.req_shape     = req_shape;
    assign bus_a.req_operation = req_op;
    assign bus_b.req_operation = req_op;
    assign bus_a.rsp_ready     = rsp_ready & ~sel;
    assign bus_b.rsp_ready     = rsp_ready & sel;
    assign bus_a.sp_read_data  = rd_data;
    assign bus_b.sp_read_data  = rd_data;

    wire [1:0]  o_req_ready     = sel ? bus_b.req_ready     : bus_a.req_ready;
    wire        o_rsp_valid     = sel ? bus_b.rsp_valid     : bus_a.rsp_valid;
    wire        o_rsp_id        = sel ? bus_b.rsp_id        : bus_a.rsp_id;
    wire        o_rsp_ok        = sel ? bus_b.rsp_ok        : bus_a.rsp_ok;
    wire        o_sp_write      = sel ? bus_b.sp_write      : bus_a.sp_write;
    wire [31:0] o_sp_write_data = sel ? bus_b.sp_write_data : bus_a.sp_write_data;
    wire        o_sp_read       = sel ? bus_b.sp_read       : bus_a.sp_read;
    wire        o_busy          = sel ? bus_b.busy          : bus_a.busy;

    // Processor model: only the enumerated legal words stick; readback is valid only in the latency slot.
    function automatic bit proc_accepts(input logic [31:0] w);
        case (w)
            32'h0001_0000, 32'h0001_0001, 32'h0001_0008,
            32'h0002_0000, 32'h0002_0001, 32'h0002_0010, 32'h0002_0011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (o_sp_write && proc_accepts(o_sp_write_data)) proc_reg <= o_sp_write_data;
        rd_sr <= {rd_sr[1:0], o_sp_read};
    end

    assign rd_valid = sel ? rd_sr[2] : rd_sr[0];
    assign rd_data  = rd_valid ? proc_reg : 32'hFFFF_FFFF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (o_req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
        chk(name, 32'(n < 20), 32'd1);
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (o_rsp_valid == 1'b0 && n < 20) begin @(negedge clk); #1; n++; end
        chk(name, 32'(n < 20), 32'd1);
    endtask

    task automatic do_req(input int id, input logic [1:0] shape, input logic [4:0] op,
                          input bit legal, input bit exp_ok, input int lat);
        logic [31:0] exp_word;
        exp_word = {14'd0, shape, 11'd0, op};
        req_shape[2*id +: 2] = shape;
        req_op[5*id +: 5]    = op;
        req_valid[id]        = 1'b1;
        #1;
        wait_grant("grant_timeout");
        chk("grant_onehot", 32'(o_req_ready), 32'(2'b01 << id));
        @(negedge clk); #1;
        req_valid[id] = 1'b0;
        if (PRECHECK && !legal) begin
            chk("fast_rsp_valid", 32'(o_rsp_valid), 32'd1);
            chk("fast_no_write", 32'(o_sp_write), 32'd0);
            chk("fast_no_read", 32'(o_sp_read), 32'd0);
        end else begin
            chk("write_strobe", 32'(o_sp_write), 32'd1);
            chk("write_data", o_sp_write_data, exp_word);
            chk("write_no_read", 32'(o_sp_read), 32'd0);
            @(negedge clk); #1;
            chk("read_strobe", 32'(o_sp_read), 32'd1);
            chk("read_no_write", 32'(o_sp_write), 32'd0);
            for (int k = 0; k < lat; k++) begin
                @(negedge clk); #1;
                chk("wait_no_rsp", 32'(o_rsp_valid), 32'd0);
            end
            @(negedge clk); #1;
            chk("rsp_valid", 32'(o_rsp_valid), 32'd1);
        end
        chk("rsp_id", 32'(o_rsp_id), 32'(id));
        chk("rsp_ok", 32'(o_rsp_ok), 32'(exp_ok));
        chk("busy_in_resp", 32'(o_busy), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_done", 32'(o_rsp_valid), 32'd0);
        chk("idle_after_rsp", 32'(o_busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(o_req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(o_rsp_id), 32'd0);
        chk({tag, "_rsp_ok"}, 32'(o_rsp_ok), 32'd0);
        chk({tag, "_sp_write"}, 32'(o_sp_write), 32'd0);
        chk({tag, "_sp_write_data"}, o_sp_write_data, 32'd0);
        chk({tag, "_sp_read"}, 32'(o_sp_read), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 2'b01, 5'b00001, 1'b1, 1'b1};
        vecs[1] = '{1, 2'b01, 5'b10000, 1'b0, 1'b0};
        vecs[2] = '{0, 2'b10, 5'b10001, 1'b1, 1'b1};
        vecs[3] = '{1, 2'b10, 5'b01000, 1'b0, 1'b0};
        vecs[4] = '{0, 2'b01, 5'b01000, 1'b1, 1'b1};
        vecs[5] = '{1, 2'b11, 5'b00000, 1'b0, 1'b0};
        vecs[6] = '{0, 2'b10, 5'b00000, 1'b1, 1'b1};
        vecs[7] = '{1, 2'b01, 5'b11000, 1'b0, 1'b0};
        vecs[8] = '{1, 2'b01, 5'b00000, 1'b1, 1'b1};

        rst_n = 1'b0; sel = 1'b0; req_valid = 2'b00; req_shape = '0; req_op = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;

        for (int v = 0; v < 9; v++)
            do_req(vecs[v].id, vecs[v].shape, vecs[v].op, vecs[v].legal, vecs[v].exp_ok, 1);

        // Round-robin with both requesters held valid
        req_shape = 4'b10_01;
        req_op    = {5'b10000, 5'b00001};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        for (int r = 0; r < 4; r++) begin
            wait_grant("rr_grant_timeout");
            chk("rr_grant", 32'(o_req_ready), (r % 2 == 1) ? 32'd2 : 32'd1);
            wait_rsp("rr_rsp_timeout");
            chk("rr_rsp_id", 32'(o_rsp_id), 32'(r % 2));
            chk("rr_rsp_ok", 32'(o_rsp_ok), 32'd1);
            if (r == 3) req_valid = 2'b00;
            @(negedge clk); #1;
        end
        rsp_ready = 1'b0;

        // Response backpressure with a competing request pending
        req_valid = 2'b01;
        #1;
        wait_grant("bp_grant_timeout");
        chk("bp_grant", 32'(o_req_ready), 32'd1);
        @(negedge clk); #1;
        req_valid = 2'b10;
        wait_rsp("bp_rsp_timeout");
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", 32'(o_rsp_valid), 32'd1);
            chk("bp_id", 32'(o_rsp_id), 32'd0);
            chk("bp_ok", 32'(o_rsp_ok), 32'd1);
            chk("bp_no_grant", 32'(o_req_ready), 32'd0);
            chk("bp_no_write", 32'(o_sp_write), 32'd0);
            @(negedge clk); #1;
        end
        chk("bp_still_valid", 32'(o_rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_next_grant", 32'(o_req_ready), 32'd2);
        @(negedge clk); #1;
        req_valid = 2'b00;
        wait_rsp("bp_next_rsp_timeout");
        chk("bp_next_id", 32'(o_rsp_id), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;

        // READ_LATENCY=3 instance: readback only valid in cycle 5
        sel = 1'b1;
        @(negedge clk); #1;
        do_req(0, 2'b01, 5'b00001, 1'b1, 1'b1, 3);

        // Reset during WAIT, with rr_ptr left at 1 by the previous request
        req_shape[1:0] = 2'b10;
        req_op[4:0]    = 5'b10001;
        req_valid      = 2'b01;
        #1;
        wait_grant("rst_setup_timeout");
        chk("rst_setup_grant", 32'(o_req_ready), 32'd1);
        @(negedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rst_setup_busy", 32'(o_busy), 32'd1);
        chk("rst_setup_no_rsp", 32'(o_rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_hold_no_rsp", 32'(o_rsp_valid), 32'd0);
        end
        rst_n     = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("post_rst_grant", 32'(o_req_ready), 32'd1);
        @(negedge clk); #1;
        req_valid = 2'b00;
        wait_rsp("post_rst_rsp_timeout");
        chk("post_rst_id", 32'(o_rsp_id), 32'd0);
        chk("post_rst_ok", 32'(o_rsp_ok), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
